// File: rtl/program_loader_if.sv
// Boot loader bus bundle.
// Groups the byte-stream handshake from the UART receiver, the CPU-side
// memory request, the memory-side bus and the CPU control outputs.
//   slave  : the loader's view (consumes rx/cpu, drives mem/cpu_reset/done)
//   master : the surrounding system's view (the mirror image)
interface program_loader_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [ADDR_WIDTH-1:0] cpu_address;
  logic [31:0]           cpu_data_out;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_data;
  logic                  mem_we;
  logic                  cpu_reset;
  logic                  done;

  modport slave (
    input  rx_data, rx_valid, cpu_address, cpu_data_out, cpu_we,
    output rx_ready, mem_address, mem_data, mem_we, cpu_reset, done
  );

  modport master (
    output rx_data, rx_valid, cpu_address, cpu_data_out, cpu_we,
    input  rx_ready, mem_address, mem_data, mem_we, cpu_reset, done
  );
endinterface

// File: rtl/program_loader.sv
// Boot-time program loader.
// Holds the CPU in reset while a length-prefixed image arrives byte by byte:
// a big-endian 16-bit word count N followed by N big-endian 32-bit words.
// Each assembled word is written to BASE_ADDR+index (wrapping). After the
// last word (or immediately when N==0) the CPU is released and the memory
// bus is handed to it through a zero-latency mux.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   bus (slave)  : rx_data/rx_valid/rx_ready byte handshake,
//                  cpu_address/cpu_data_out/cpu_we CPU request,
//                  mem_address/mem_data/mem_we memory bus,
//                  cpu_reset (flop-driven) and done status
module program_loader #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input logic             clock,
  input logic             reset,
  program_loader_if.slave bus
);

  typedef enum logic [2:0] {LEN_HI, LEN_LO, BYTES, WRITE, RUN} state_t;

  // Wide enough to compare index+1 against the 16-bit count without loss.
  localparam int unsigned CW = (ADDR_WIDTH > 16) ? ADDR_WIDTH : 16;

  state_t                state;
  logic [15:0]           count;
  logic [ADDR_WIDTH-1:0] index;
  logic [1:0]            byte_cnt;
  logic [31:0]           shift;
  logic                  cpu_reset_q;

  logic                  ready_int;
  logic                  accept;
  logic [15:0]           len_next;
  logic [ADDR_WIDTH-1:0] index_inc;
  logic                  last_word;
  logic [ADDR_WIDTH-1:0] load_addr;

  always_comb begin
    ready_int = (state == LEN_HI) || (state == LEN_LO) || (state == BYTES);
    accept    = bus.rx_valid & ready_int;
    len_next  = {count[15:8], bus.rx_data};
    index_inc = index + ADDR_WIDTH'(1);
    last_word = (CW'(index) + CW'(1)) == CW'(count);
    load_addr = BASE_ADDR + index;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= LEN_HI;
      count       <= '0;
      index       <= '0;
      byte_cnt    <= '0;
      shift       <= '0;
      cpu_reset_q <= 1'b1;
    end else begin
      case (state)
        LEN_HI: begin
          if (accept) begin
            count[15:8] <= bus.rx_data;
            state       <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            count[7:0] <= bus.rx_data;
            if (len_next == '0) begin
              state       <= RUN;
              cpu_reset_q <= 1'b0;
            end else begin
              state <= BYTES;
            end
          end
        end
        BYTES: begin
          if (accept) begin
            shift    <= {shift[23:0], bus.rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) state <= WRITE;
          end
        end
        WRITE: begin
          index <= index_inc;
          if (last_word) begin
            state       <= RUN;
            cpu_reset_q <= 1'b0;
          end else begin
            state <= BYTES;
          end
        end
        RUN: begin
        end
        default: state <= LEN_HI;
      endcase
    end
  end

  assign bus.rx_ready    = ready_int;
  assign bus.cpu_reset   = cpu_reset_q;
  assign bus.done        = (state == RUN);
  assign bus.mem_address = (state == RUN) ? bus.cpu_address  : load_addr;
  assign bus.mem_data    = (state == RUN) ? bus.cpu_data_out : shift;
  assign bus.mem_we      = (state == RUN) ? bus.cpu_we       : (state == WRITE);

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (base 0x0000 and 0xFFFF) share
// the same byte stream; loads are checked against write lists and timing
// derived from the image format.
module tb_program_loader;
  localparam int unsigned AW = 16;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];
  typedef int          int_q_t[$];
  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  program_loader_if #(.ADDR_WIDTH(AW)) bus0 ();
  program_loader_if #(.ADDR_WIDTH(AW)) bus1 ();

  program_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(16'h0000)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0)
  );
  program_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(16'hFFFF)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1)
  );

  assign bus1.rx_data      = bus0.rx_data;
  assign bus1.rx_valid     = bus0.rx_valid;
  assign bus1.cpu_address  = bus0.cpu_address;
  assign bus1.cpu_data_out = bus0.cpu_data_out;
  assign bus1.cpu_we       = bus0.cpu_we;

  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  rel_cyc = -1;
  int  done_cyc = -1;
  wr_t wr0[$];
  wr_t wr1[$];

  always @(posedge clock) cyc++;

  // Loader-issued writes only happen while the CPU is held in reset.
  always @(negedge clock) begin
    if (bus0.mem_we === 1'b1 && bus0.cpu_reset === 1'b1)
      wr0.push_back('{bus0.mem_address, bus0.mem_data, cyc});
    if (bus1.mem_we === 1'b1 && bus1.cpu_reset === 1'b1)
      wr1.push_back('{bus1.mem_address, bus1.mem_data, cyc});
    if (!reset && bus0.cpu_reset === 1'b0 && rel_cyc < 0) rel_cyc = cyc;
    if (!reset && bus0.done === 1'b1 && done_cyc < 0) done_cyc = cyc;
  end

  task automatic apply_reset();
    bus0.rx_valid = 1'b0;
    bus0.cpu_we   = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (bus0.cpu_reset !== 1'b1 || bus1.cpu_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL async_cpu_reset got %b/%b want 1", bus0.cpu_reset, bus1.cpu_reset);
    end
    vectors++;
    if (bus0.done !== 1'b0 || bus1.done !== 1'b0) begin
      miscompares++;
      $display("FAIL async_done got %b/%b want 0", bus0.done, bus1.done);
    end
    @(negedge clock);
    #2 reset = 1'b0;
    wr0 = {};
    wr1 = {};
    rel_cyc  = -1;
    done_cyc = -1;
  endtask

  // Presents img one byte at a time, holding a byte until it is taken.
  // mode 0: always valid, 1: valid every other cycle, 2: random valid.
  task automatic drive_stream(input byte_q_t img, input int unsigned mode,
                              output int_q_t acc_cyc);
    int unsigned idx = 0;
    int unsigned steps = 0;
    int unsigned budget;
    bit v = 0, prev_v = 0, prev_acc = 0, acc, in_write = 0, exp_rdy;
    int rdy_err = 0;
    budget  = 20 * img.size() + 20;
    acc_cyc = {};
    while (idx < img.size() && steps < budget) begin
      @(negedge clock);
      steps++;
      case (mode)
        0:       v = 1'b1;
        1:       v = (prev_v && !prev_acc) || (steps % 2 == 0);
        default: v = (prev_v && !prev_acc) || ($urandom_range(0, 1) == 1);
      endcase
      bus0.rx_valid = v;
      bus0.rx_data  = v ? img[idx] : 8'($urandom);
      exp_rdy = !in_write;
      #1;
      if (bus0.rx_ready !== exp_rdy || bus1.rx_ready !== exp_rdy) rdy_err++;
      acc = v && (bus0.rx_ready === 1'b1);
      if (acc) begin
        acc_cyc.push_back(cyc);
        idx++;
        in_write = (idx > 2) && ((idx - 2) % 4 == 0);
      end else begin
        in_write = 1'b0;
      end
      prev_v   = v;
      prev_acc = acc;
    end
    @(negedge clock);
    bus0.rx_valid = 1'b0;
    vectors++;
    if (idx != img.size()) begin
      miscompares++;
      $display("FAIL stream_accepted got %0d want %0d bytes", idx, img.size());
    end
    vectors++;
    if (rdy_err != 0) begin
      miscompares++;
      $display("FAIL rx_ready_timing got %0d wrong cycles want 0", rdy_err);
    end
  endtask

  task automatic test_load_image(input string name, input word_q_t words,
                                 input int unsigned mode, input bit do_reset);
    byte_q_t img;
    int_q_t  acc;
    int n, exp_rel, exp_cyc;
    logic [15:0] ea0, ea1;
    if (do_reset) apply_reset();
    n = words.size();
    img = {};
    img.push_back(8'(n >> 8));
    img.push_back(8'(n));
    foreach (words[i]) begin
      img.push_back(words[i][31:24]);
      img.push_back(words[i][23:16]);
      img.push_back(words[i][15:8]);
      img.push_back(words[i][7:0]);
    end
    wr0 = {};
    wr1 = {};
    drive_stream(img, mode, acc);
    repeat (3) @(negedge clock);
    #1;
    vectors++;
    if (wr0.size() != n) begin
      miscompares++;
      $display("FAIL %s write_count_base0 got %0d want %0d", name, wr0.size(), n);
    end
    vectors++;
    if (wr1.size() != n) begin
      miscompares++;
      $display("FAIL %s write_count_baseFFFF got %0d want %0d", name, wr1.size(), n);
    end
    for (int i = 0; i < n; i++) begin
      ea0 = 16'(i);
      ea1 = 16'(32'hFFFF + i);
      if (i < wr0.size()) begin
        vectors++;
        if (wr0[i].addr !== ea0 || wr0[i].data !== words[i]) begin
          miscompares++;
          $display("FAIL %s write%0d_base0 got %h@%h want %h@%h", name, i,
                   wr0[i].data, wr0[i].addr, words[i], ea0);
        end
        if (acc.size() > 4 * i + 5) begin
          exp_cyc = acc[4 * i + 5] + 1;
          vectors++;
          if (wr0[i].cyc != exp_cyc) begin
            miscompares++;
            $display("FAIL %s write%0d_cycle got %0d want %0d", name, i, wr0[i].cyc, exp_cyc);
          end
        end
      end
      if (i < wr1.size()) begin
        vectors++;
        if (wr1[i].addr !== ea1 || wr1[i].data !== words[i]) begin
          miscompares++;
          $display("FAIL %s write%0d_baseFFFF got %h@%h want %h@%h", name, i,
                   wr1[i].data, wr1[i].addr, words[i], ea1);
        end
      end
    end
    if (acc.size() == img.size()) begin
      exp_rel = (n == 0) ? acc[1] + 1 : acc[acc.size() - 1] + 2;
      vectors++;
      if (rel_cyc != exp_rel) begin
        miscompares++;
        $display("FAIL %s cpu_reset_release_cycle got %0d want %0d", name, rel_cyc, exp_rel);
      end
      vectors++;
      if (done_cyc != exp_rel) begin
        miscompares++;
        $display("FAIL %s done_rise_cycle got %0d want %0d", name, done_cyc, exp_rel);
      end
    end
    vectors++;
    if (bus0.done !== 1'b1 || bus1.done !== 1'b1 ||
        bus0.cpu_reset !== 1'b0 || bus1.cpu_reset !== 1'b0) begin
      miscompares++;
      $display("FAIL %s run_status got done=%b/%b cpu_reset=%b/%b want done=1 cpu_reset=0",
               name, bus0.done, bus1.done, bus0.cpu_reset, bus1.cpu_reset);
    end
    vectors++;
    if (bus0.rx_ready !== 1'b0 || bus1.rx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s run_rx_ready got %b/%b want 0", name, bus0.rx_ready, bus1.rx_ready);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    vectors++;
    if (bus0.rx_ready !== 1'b1 || bus0.mem_we !== 1'b0 || bus0.done !== 1'b0 ||
        bus0.cpu_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_outputs got rdy=%b we=%b done=%b cpu_reset=%b want 1 0 0 1",
               bus0.rx_ready, bus0.mem_we, bus0.done, bus0.cpu_reset);
    end
    vectors++;
    if (bus0.mem_address !== 16'h0000 || bus1.mem_address !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL reset_address got %h/%h want 0000/ffff", bus0.mem_address, bus1.mem_address);
    end
    vectors++;
    if (bus0.mem_data !== 32'h0 || bus1.mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_bus got data=%h we1=%b want 00000000 0", bus0.mem_data, bus1.mem_we);
    end
  endtask

  task automatic test_two_words();
    word_q_t w = {};
    w.push_back(32'h12345678);
    w.push_back(32'h9ABCDEF0);
    test_load_image("two_words", w, 0, 1'b1);
  endtask

  task automatic test_zero_length();
    word_q_t w = {};
    test_load_image("zero_length", w, 0, 1'b1);
  endtask

  task automatic test_toggle_valid();
    word_q_t w = {};
    w.push_back(32'hCAFEBABE);
    test_load_image("toggle_valid", w, 1, 1'b1);
  endtask

  task automatic test_reset_mid_load();
    byte_q_t img = {};
    int_q_t  acc;
    word_q_t w = {};
    apply_reset();
    img.push_back(8'h00);
    img.push_back(8'h01);
    img.push_back(8'hAA);
    img.push_back(8'hBB);
    drive_stream(img, 0, acc);
    @(negedge clock);
    #3 reset = 1'b1;
    #1;
    vectors++;
    if (bus0.cpu_reset !== 1'b1 || bus0.mem_we !== 1'b0 || bus1.mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL midload_reset got cpu_reset=%b we=%b/%b want 1 0 0",
               bus0.cpu_reset, bus0.mem_we, bus1.mem_we);
    end
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (wr0.size() != 0 || wr1.size() != 0 || rel_cyc != -1) begin
      miscompares++;
      $display("FAIL midload_no_write got writes=%0d/%0d rel=%0d want 0/0 -1",
               wr0.size(), wr1.size(), rel_cyc);
    end
    vectors++;
    if (bus0.rx_ready !== 1'b1 || bus0.done !== 1'b0) begin
      miscompares++;
      $display("FAIL midload_restart got rdy=%b done=%b want 1 0", bus0.rx_ready, bus0.done);
    end
    w.push_back(32'h11223344);
    test_load_image("after_midload_reset", w, 0, 1'b0);
  endtask

  task automatic test_run_passthrough();
    logic [15:0] a;
    logic [31:0] d;
    logic        we;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (i == 0) begin
        a = 16'h0010; d = 32'h00000005; we = 1'b1;
      end else begin
        a = 16'($urandom); d = $urandom; we = 1'($urandom);
      end
      bus0.cpu_address  = a;
      bus0.cpu_data_out = d;
      bus0.cpu_we       = we;
      #1;
      vectors++;
      if (bus0.mem_address !== a || bus0.mem_data !== d || bus0.mem_we !== we ||
          bus1.mem_address !== a || bus1.mem_data !== d || bus1.mem_we !== we) begin
        miscompares++;
        $display("FAIL passthrough%0d got %h %h %b / %h %h %b want %h %h %b", i,
                 bus0.mem_address, bus0.mem_data, bus0.mem_we,
                 bus1.mem_address, bus1.mem_data, bus1.mem_we, a, d, we);
      end
    end
    bus0.rx_valid = 1'b1;
    bus0.rx_data  = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      vectors++;
      if (bus0.rx_ready !== 1'b0 || bus0.done !== 1'b1 || bus0.cpu_reset !== 1'b0 ||
          bus0.mem_address !== bus0.cpu_address || bus1.rx_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL run_ignores_rx%0d got rdy=%b done=%b cpu_reset=%b addr=%h want 0 1 0 %h",
                 i, bus0.rx_ready, bus0.done, bus0.cpu_reset, bus0.mem_address, bus0.cpu_address);
      end
    end
    bus0.rx_valid = 1'b0;
    bus0.cpu_we   = 1'b0;
  endtask

  task automatic test_random_images();
    word_q_t w;
    int unsigned n;
    for (int t = 0; t < 6; t++) begin
      w = {};
      n = $urandom_range(0, 5);
      for (int unsigned k = 0; k < n; k++) w.push_back($urandom);
      test_load_image($sformatf("random%0d", t), w, $urandom_range(0, 2), 1'b1);
    end
  endtask

  initial begin
    bus0.rx_valid     = 1'b0;
    bus0.rx_data      = 8'h00;
    bus0.cpu_address  = '0;
    bus0.cpu_data_out = '0;
    bus0.cpu_we       = 1'b0;
    test_reset();
    test_two_words();
    test_zero_length();
    test_toggle_valid();
    test_reset_mid_load();
    test_run_passthrough();
    test_random_images();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time loader sitting between a byte-stream source (UART receiver) and the unified program/data memory, directly upstream of the CPU.
- Holds the CPU in reset and receives a length-prefixed program image. Assembles bytes into 32-bit words and writes them sequentially into memory.
- Once the image is loaded, releases the CPU and hands the memory bus over to it through a pass-through mux.

Parameters:
- ADDR_WIDTH, 16, memory word-address width; matches the CPU address bus.
- BASE_ADDR, 16'h0000, word address of the first loaded word (the CPU reset vector).

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data holds a valid byte.
- rx_ready  output  1  loader can accept a byte; a byte transfers on a posedge where rx_valid & rx_ready.
- cpu_address  input  ADDR_WIDTH  CPU address request.
- cpu_data_out  input  32  CPU write data.
- cpu_we  input  1  CPU write enable.
- mem_address  output  ADDR_WIDTH  address to memory.
- mem_data  output  32  write data to memory.
- mem_we  output  1  memory write enable.
- cpu_reset  output  1  active-high reset to the CPU; registered.
- done  output  1  high once loading has completed.

Behaviour:
- Image format:
  - 2-byte word count N, big-endian (high byte first).
  - Followed by 4*N bytes; each word is big-endian, MSB byte first.
- States: LEN_HI, LEN_LO, BYTES, WRITE, RUN. Registers: state, count[15:0], index[ADDR_WIDTH-1:0], byte_cnt[1:0], shift[31:0], cpu_reset.
- Reset (asynchronous, active-high): state=LEN_HI, count=0, index=0, byte_cnt=0, shift=0, cpu_reset=1. Outputs after reset: rx_ready=1, mem_we=0, done=0.
- LEN_HI: on accept, count[15:8]=rx_data, go to LEN_LO.
- LEN_LO: on accept, count[7:0]=rx_data.
  - If the resulting N==0, go to RUN and clear cpu_reset at the same edge.
  - Otherwise go to BYTES.
- BYTES: on accept, shift={shift[23:0],rx_data} and byte_cnt increments. On the accept where byte_cnt==3, byte_cnt wraps to 0 and state goes to WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_address=BASE_ADDR+index, mem_data=shift.
  - At the end of the cycle, index increments.
  - If index+1==count, go to RUN and clear cpu_reset at the same edge. Otherwise go back to BYTES.
- RUN is terminal until reset. done=1 and cpu_reset=0 in RUN.
- rx_ready: combinational, 1 only in LEN_HI, LEN_LO and BYTES; 0 in WRITE and RUN. A byte presented during WRITE stays pending (not consumed) and is accepted in BYTES. Bytes presented in RUN are ignored.
- Bus mux:
  - In RUN: mem_address=cpu_address, mem_data=cpu_data_out, mem_we=cpu_we, combinationally with zero latency.
  - In non-RUN states: loader drives the bus; CPU inputs are ignored.
  - In non-WRITE loader states: mem_address=BASE_ADDR+index, mem_data=shift, mem_we=0.
- Address arithmetic: BASE_ADDR+index is computed modulo 2^ADDR_WIDTH (wraps).
- N=65535 is legal; index never overflows before count is reached.
- Throughput: at most one byte per cycle. One word costs at least 5 cycles (4 accepts plus WRITE).
- Reset mid-load:
  - Partially assembled word is discarded and no write is issued; loading restarts at LEN_HI.
  - Words already written remain in memory.
  - cpu_reset reasserts immediately (async).
- Reset while in RUN: CPU is re-held in reset and a fresh image is expected.
- cpu_reset is driven from a flop only, never from combinational logic (glitch-free into the CPU's asynchronous reset). The CPU begins its first fetch at BASE_ADDR on the first posedge after cpu_reset falls.

Test Plan:
- Stream 00 02 12 34 56 78 9A BC DE F0 at one byte per cycle:
  - mem_we pulses exactly twice, one cycle each: 0x12345678 @0x0000, then 0x9ABCDEF0 @0x0001.
  - rx_ready=0 during each WRITE cycle.
  - cpu_reset falls and done rises on the edge ending the second WRITE.
- Stream 00 00 -> RUN entered on the LEN_LO accept edge; mem_we never asserts; done=1.
- N=1 word 0xCAFEBABE with rx_valid toggling every other cycle and held high through WRITE -> single write of 0xCAFEBABE @0x0000; no byte lost or duplicated.
- BASE_ADDR=16'hFFFF, N=2 -> writes land at 0xFFFF then 0x0000.
- Send 00 01 AA BB, then pulse reset asynchronously mid-cycle:
  - No mem_we occurs; cpu_reset stays 1.
  - Subsequent 00 01 11 22 33 44 writes 0x11223344 @BASE_ADDR.
- In RUN, drive cpu_address=0x0010, cpu_data_out=0x00000005, cpu_we=1 -> identical values appear on mem_* the same cycle; rx_valid=1 yields rx_ready=0 and no state change.
